// File: rtl/seq_matmul_mac.sv
// Sequential signed matrix multiplier: Z = A x B or Z = Zprev + A x B.
// A single shared MAC consumes one product term per cycle in row-major order.
module seq_matmul_mac #(
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int P   = 4,
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M*N*W-1:0]   input_a,
  input  logic               input_a_stb,
  output logic               input_a_ack,
  input  logic [N*P*W-1:0]   input_b,
  input  logic               input_b_stb,
  output logic               input_b_ack,
  input  logic               accumulate,
  output logic [M*P*W-1:0]   output_z,
  output logic               output_z_stb,
  input  logic               output_z_ack,
  output logic               busy
);

  localparam int PW    = 2 * W;
  localparam int ACC_W = 2 * W + $clog2(N);
  localparam int SUM_W = ACC_W + 1;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (P > 1) ? $clog2(P) : 1;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int ABW   = $clog2(M * N * W);
  localparam int BBW   = $clog2(N * P * W);
  localparam int ZBW   = $clog2(M * P * W);

  localparam logic signed [SUM_W-1:0] Z_MAX = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Z_MIN = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  function automatic logic signed [W-1:0] fit_w(input logic signed [SUM_W-1:0] s);
    logic signed [W-1:0] r;
    r = s[W-1:0];
    if (SAT) begin
      if (s > Z_MAX)      r = Z_MAX[W-1:0];
      else if (s < Z_MIN) r = Z_MIN[W-1:0];
    end
    return r;
  endfunction

  state_t                    state_q, state_d;
  logic                      a_cap_q, a_cap_d;
  logic                      b_cap_q, b_cap_d;
  logic                      acc_mode_q, acc_mode_d;
  logic                      rdy_q, rdy_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  logic [KW-1:0]             k_q, k_d;
  logic [M*P*W-1:0]          z_q, z_d;
  logic [M*N*W-1:0]          a_q, a_d;
  logic [N*P*W-1:0]          b_q, b_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  logic                      a_fire, b_fire;
  logic [ABW-1:0]            a_base;
  logic [BBW-1:0]            b_base;
  logic [ZBW-1:0]            z_base;
  logic signed [W-1:0]       a_el, b_el, z_old;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   mac;
  logic signed [SUM_W-1:0]   zp, sum;

  assign input_a_ack  = rdy_q && (state_q == IDLE) && !a_cap_q;
  assign input_b_ack  = rdy_q && (state_q == IDLE) && !b_cap_q;
  assign a_fire       = input_a_stb && input_a_ack;
  assign b_fire       = input_b_stb && input_b_ack;
  assign output_z_stb = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign output_z     = z_q;

  // MAC datapath: current term a[i][k]*b[k][j] plus running sum and optional Zprev
  always_comb begin
    a_base = ABW'((int'(i_q) * N + int'(k_q)) * W);
    b_base = BBW'((int'(k_q) * P + int'(j_q)) * W);
    z_base = ZBW'((int'(i_q) * P + int'(j_q)) * W);
    a_el   = a_q[a_base +: W];
    b_el   = b_q[b_base +: W];
    z_old  = z_q[z_base +: W];
    prod   = PW'(a_el) * PW'(b_el);
    mac    = acc_q + ACC_W'(prod);
    zp     = acc_mode_q ? SUM_W'(z_old) : '0;
    sum    = SUM_W'(mac) + zp;
  end

  always_comb begin
    state_d    = state_q;
    a_cap_d    = a_cap_q;
    b_cap_d    = b_cap_q;
    acc_mode_d = acc_mode_q;
    rdy_d      = 1'b1;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    z_d        = z_q;
    acc_d      = acc_q;
    a_d        = a_fire ? input_a : a_q;
    b_d        = b_fire ? input_b : b_q;
    unique case (state_q)
      IDLE: begin
        if (a_fire) begin
          a_cap_d    = 1'b1;
          acc_mode_d = accumulate;
        end
        if (b_fire) b_cap_d = 1'b1;
        if ((a_cap_q || a_fire) && (b_cap_q || b_fire)) begin
          state_d = COMPUTE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      COMPUTE: begin
        if (k_q == KW'(N - 1)) begin
          z_d[z_base +: W] = fit_w(sum);
          acc_d = '0;
          k_d   = '0;
          if (j_q == JW'(P - 1)) begin
            j_d = '0;
            if (i_q == IW'(M - 1)) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = mac;
          k_d   = k_q + 1'b1;
        end
      end
      DONE: begin
        if (output_z_ack) begin
          state_d = IDLE;
          a_cap_d = 1'b0;
          b_cap_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and result registers; reset also clears the held Z
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_cap_q    <= 1'b0;
      b_cap_q    <= 1'b0;
      acc_mode_q <= 1'b0;
      rdy_q      <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      z_q        <= '0;
    end else begin
      state_q    <= state_d;
      a_cap_q    <= a_cap_d;
      b_cap_q    <= b_cap_d;
      acc_mode_q <= acc_mode_d;
      rdy_q      <= rdy_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      z_q        <= z_d;
    end
  end

  // Operand copies and partial sum need no reset: both are loaded before use
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_seq_matmul_mac.sv
// Directed bench for seq_matmul_mac: four parameterisations (4x4x4/32, 2x3x2/16,
// 2x4x2/8 saturating and wrapping) driven from vector tables plus corner sequences.
module tb_seq_matmul_mac;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int lat;

  wire  [3:0] zstb, aack, back, busyv;
  logic [3:0] zack;

  logic [511:0] id_a, id_b;
  wire  [511:0] id_z;
  logic         id_a_stb, id_b_stb, id_acc;

  logic [95:0]  ns_a, ns_b;
  wire  [63:0]  ns_z;
  logic         ns_a_stb, ns_b_stb, ns_acc;

  logic [63:0]  s_a, s_b;
  wire  [31:0]  s1_z, s0_z;
  logic         s_a_stb, s_b_stb, s_acc;

  seq_matmul_mac #(.M(4), .N(4), .P(4), .W(32), .SAT(1'b1)) u_id (
    .clk(clk), .rst(rst),
    .input_a(id_a), .input_a_stb(id_a_stb), .input_a_ack(aack[0]),
    .input_b(id_b), .input_b_stb(id_b_stb), .input_b_ack(back[0]),
    .accumulate(id_acc),
    .output_z(id_z), .output_z_stb(zstb[0]), .output_z_ack(zack[0]), .busy(busyv[0]));

  seq_matmul_mac #(.M(2), .N(3), .P(2), .W(16), .SAT(1'b1)) u_ns (
    .clk(clk), .rst(rst),
    .input_a(ns_a), .input_a_stb(ns_a_stb), .input_a_ack(aack[1]),
    .input_b(ns_b), .input_b_stb(ns_b_stb), .input_b_ack(back[1]),
    .accumulate(ns_acc),
    .output_z(ns_z), .output_z_stb(zstb[1]), .output_z_ack(zack[1]), .busy(busyv[1]));

  seq_matmul_mac #(.M(2), .N(4), .P(2), .W(8), .SAT(1'b1)) u_s1 (
    .clk(clk), .rst(rst),
    .input_a(s_a), .input_a_stb(s_a_stb), .input_a_ack(aack[2]),
    .input_b(s_b), .input_b_stb(s_b_stb), .input_b_ack(back[2]),
    .accumulate(s_acc),
    .output_z(s1_z), .output_z_stb(zstb[2]), .output_z_ack(zack[2]), .busy(busyv[2]));

  seq_matmul_mac #(.M(2), .N(4), .P(2), .W(8), .SAT(1'b0)) u_s0 (
    .clk(clk), .rst(rst),
    .input_a(s_a), .input_a_stb(s_a_stb), .input_a_ack(aack[3]),
    .input_b(s_b), .input_b_stb(s_b_stb), .input_b_ack(back[3]),
    .accumulate(s_acc),
    .output_z(s0_z), .output_z_stb(zstb[3]), .output_z_ack(zack[2]), .busy(busyv[3]));

  typedef struct packed {
    logic [95:0] a;
    logic [95:0] b;
    logic        acc;
    logic [63:0] z;
  } ns_vec_t;

  typedef struct packed {
    logic signed [7:0] av;
    logic signed [7:0] bv;
    logic signed [7:0] z_sat;
    logic signed [7:0] z_wrap;
  } sat_vec_t;

  ns_vec_t  ns_tab [4];
  sat_vec_t sat_tab [7];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_z(input int u, input int bound, output int l);
    l = -1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk);
      #1;
      if (zstb[u]) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic z_take(input int u);
    @(negedge clk);
    zack[u] = 1'b1;
    @(posedge clk);
    #1;
    zack[u] = 1'b0;
    chk("z_stb_drop", zstb[u], 0);
    chk("busy_clear", busyv[u], 0);
    chk("a_ack_back", aack[u], 1);
    chk("b_ack_back", back[u], 1);
  endtask

  task automatic id_load_ident();
    for (int e = 0; e < 16; e++) begin
      id_a[e*32 +: 32] = (e / 4 == e % 4) ? 32'd1 : 32'd0;
      id_b[e*32 +: 32] = 32'(e + 1);
    end
  endtask

  task automatic id_job(input string tag);
    int l;
    @(negedge clk);
    id_load_ident();
    id_acc   = 1'b0;
    id_a_stb = 1'b1;
    id_b_stb = 1'b1;
    @(posedge clk);
    #1;
    id_a_stb = 1'b0;
    id_b_stb = 1'b0;
    chk({tag, "_busy_e0"}, busyv[0], 1);
    chk({tag, "_acks_e0"}, {aack[0], back[0]}, 0);
    wait_z(0, 200, l);
    chk({tag, "_latency"}, l, 64);
    for (int e = 0; e < 16; e++) chk({tag, "_z"}, $signed(id_z[e*32 +: 32]), e + 1);
    z_take(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ns_tab[0].a   = {16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1};
    ns_tab[0].b   = {16'sd12, 16'sd11, 16'sd10, 16'sd9, 16'sd8, 16'sd7};
    ns_tab[0].acc = 1'b0;
    ns_tab[0].z   = {16'sd154, 16'sd139, 16'sd64, 16'sd58};
    ns_tab[1]     = ns_tab[0];
    ns_tab[1].acc = 1'b1;
    ns_tab[1].z   = {16'sd308, 16'sd278, 16'sd128, 16'sd116};
    ns_tab[2]     = ns_tab[0];
    ns_tab[3].a   = {16'sd0, -16'sd4, 16'sd3, 16'sd2, 16'sd0, -16'sd1};
    ns_tab[3].b   = ns_tab[0].b;
    ns_tab[3].acc = 1'b0;
    ns_tab[3].z   = {-16'sd16, -16'sd15, 16'sd16, 16'sd15};

    sat_tab[0] = {8'sd127, 8'sd127, 8'sd127, 8'sd4};
    sat_tab[1] = {8'h80,   8'sd127, 8'h80,   8'sd0};
    sat_tab[2] = {8'sd3,   -8'sd5,  -8'sd60, -8'sd60};
    sat_tab[3] = {8'sd100, 8'sd2,   8'sd127, 8'sd32};
    sat_tab[4] = {8'h80,   8'h80,   8'sd127, 8'sd0};
    sat_tab[5] = {-8'sd32, 8'sd1,   8'h80,   8'h80};
    sat_tab[6] = {-8'sd33, 8'sd1,   8'h80,   8'sd124};

    zack = '0;
    id_a = '0; id_b = '0; id_a_stb = 1'b0; id_b_stb = 1'b0; id_acc = 1'b0;
    ns_a = '0; ns_b = '0; ns_a_stb = 1'b0; ns_b_stb = 1'b0; ns_acc = 1'b0;
    s_a  = '0; s_b  = '0; s_a_stb  = 1'b0; s_b_stb  = 1'b0; s_acc  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_z_zero", (id_z != '0) || (ns_z != '0) || (s1_z != '0) || (s0_z != '0), 0);
    chk("rst_stb", zstb, 0);
    chk("rst_busy", busyv, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_a_ack", aack, 4'hf);
    chk("post_rst_b_ack", back, 4'hf);

    id_job("ident");

    // B first, A five cycles later; Z held while unacknowledged
    @(negedge clk);
    for (int e = 0; e < 16; e++) begin
      id_a[e*32 +: 32] = (e / 4 == e % 4) ? 32'd2 : 32'd0;
      id_b[e*32 +: 32] = 32'(3 * e - 20);
    end
    id_b_stb = 1'b1;
    @(posedge clk);
    #1;
    id_b_stb = 1'b0;
    id_b     = '1;
    chk("hs_b_ack_drop", back[0], 0);
    chk("hs_a_ack_hold", aack[0], 1);
    chk("hs_idle_busy", busyv[0], 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    id_a_stb = 1'b1;
    @(posedge clk);
    #1;
    id_a_stb = 1'b0;
    id_a     = '0;
    chk("hs_busy_e0", busyv[0], 1);
    wait_z(0, 200, lat);
    chk("hs_latency", lat, 64);
    id_a_stb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("hs_hold_stb", zstb[0], 1);
      chk("hs_hold_a_ack", aack[0], 0);
      chk("hs_hold_z", $signed(id_z[15*32 +: 32]), 2 * (3 * 15 - 20));
    end
    id_a_stb = 1'b0;
    for (int e = 0; e < 16; e++) chk("hs_z", $signed(id_z[e*32 +: 32]), 2 * (3 * e - 20));
    z_take(0);

    // Reset in the middle of a job
    @(negedge clk);
    id_load_ident();
    id_a_stb = 1'b1;
    id_b_stb = 1'b1;
    @(posedge clk);
    #1;
    id_a_stb = 1'b0;
    id_b_stb = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_z", id_z != '0, 0);
    chk("mid_rst_stb", zstb[0], 0);
    chk("mid_rst_busy", busyv[0], 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_a_ack", aack[0], 1);
    chk("mid_rst_b_ack", back[0], 1);
    id_job("post_rst");

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      ns_a     = ns_tab[v].a;
      ns_b     = ns_tab[v].b;
      ns_acc   = ns_tab[v].acc;
      ns_a_stb = 1'b1;
      ns_b_stb = 1'b1;
      @(posedge clk);
      #1;
      ns_a_stb = 1'b0;
      ns_b_stb = 1'b0;
      ns_acc   = 1'b0;
      wait_z(1, 100, lat);
      chk("ns_latency", lat, 12);
      for (int e = 0; e < 4; e++)
        chk("ns_z", $signed(ns_z[e*16 +: 16]), $signed(ns_tab[v].z[e*16 +: 16]));
      z_take(1);
    end

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      s_a     = {8{sat_tab[v].av}};
      s_b     = {8{sat_tab[v].bv}};
      s_a_stb = 1'b1;
      s_b_stb = 1'b1;
      @(posedge clk);
      #1;
      s_a_stb = 1'b0;
      s_b_stb = 1'b0;
      wait_z(2, 100, lat);
      chk("sat_latency", lat, 16);
      chk("wrap_stb", zstb[3], 1);
      for (int e = 0; e < 4; e++) begin
        chk("sat_z", $signed(s1_z[e*8 +: 8]), sat_tab[v].z_sat);
        chk("wrap_z", $signed(s0_z[e*8 +: 8]), sat_tab[v].z_wrap);
      end
      z_take(2);
      chk("wrap_stb_drop", zstb[3], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
